// File: rtl/ans_delay_generator.sv
// ans_delay_generator
// Responder-side answer-delay gate. After the last RX stop bit it holds off the
// local transmitter for DelaySet_i acquisition ticks, then releases exactly one
// TX start pulse, either for a request already pending or for one that arrives
// while armed. It reports the measured turnaround in ticks on DelayCnt_o.
//
// Ports:
//   clk, rst        system clock; asynchronous active-low reset
//   DelaySet_i      required answer delay in ticks
//   MaxWait_i       ticks to wait for a request after the delay; 0 = forever
//   p_RxFrameEnd_i  pulse at the last RX stop bit; starts/restarts the delay
//   p_TxReq_i       pulse: upper module has a response ready
//   p_Abort_i       pulse: cancel any pending delay or request
//   AcqSig_i        tick strobe (0.1 ms)
//   p_TxStart_o     registered one-cycle start pulse to the TX core
//   p_TxMissed_o    registered one-cycle pulse: no request within MaxWait_i
//   Busy_o          registered, high in DELAY or ARMED
//   DelayCnt_o      elapsed ticks since the last frame end (saturating)
//   State_o         IDLE=00, DELAY=01, ARMED=10
module ans_delay_generator #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] DelaySet_i,
  input  logic [CNT_WIDTH-1:0] MaxWait_i,
  input  logic                 p_RxFrameEnd_i,
  input  logic                 p_TxReq_i,
  input  logic                 p_Abort_i,
  input  logic                 AcqSig_i,
  output logic                 p_TxStart_o,
  output logic                 p_TxMissed_o,
  output logic                 Busy_o,
  output logic [CNT_WIDTH-1:0] DelayCnt_o,
  output logic [1:0]           State_o
);

  localparam int unsigned LIM_WIDTH = CNT_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DELAY = 2'b01,
    ST_ARMED = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic                   tx_start_d, tx_missed_d;

  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic [LIM_WIDTH-1:0]   timeout_lim;
  logic                   delay_done;
  logic                   timed_out;

  // Saturating increment: the counter never wraps back to a small value.
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign delay_done  = (cnt_q >= DelaySet_i);
  // One extra bit so DelaySet_i + MaxWait_i cannot overflow.
  assign timeout_lim = LIM_WIDTH'(DelaySet_i) + LIM_WIDTH'(MaxWait_i);
  assign timed_out   = (MaxWait_i != '0) && (LIM_WIDTH'(cnt_q) >= timeout_lim);

  // Next-state and next-output logic; priority abort > frame end > request > tick/compare.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    tx_start_d  = 1'b0;
    tx_missed_d = 1'b0;

    if (p_Abort_i) begin
      state_d   = ST_IDLE;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (p_RxFrameEnd_i) begin
            state_d   = ST_DELAY;
            cnt_d     = '0;
            pending_d = p_TxReq_i;
          end else if (p_TxReq_i) begin
            // Unsolicited transmit: no delay constraint outside a frame turnaround.
            tx_start_d = 1'b1;
          end
        end

        ST_DELAY: begin
          if (p_RxFrameEnd_i) begin
            cnt_d     = '0;
            pending_d = pending_q | p_TxReq_i;
          end else begin
            if (AcqSig_i) begin
              cnt_d = cnt_inc;
            end
            if (delay_done) begin
              if (pending_q || p_TxReq_i) begin
                tx_start_d = 1'b1;
                state_d    = ST_IDLE;
                pending_d  = 1'b0;
              end else begin
                state_d = ST_ARMED;
              end
            end else if (p_TxReq_i) begin
              pending_d = 1'b1;
            end
          end
        end

        ST_ARMED: begin
          if (p_RxFrameEnd_i) begin
            state_d   = ST_DELAY;
            cnt_d     = '0;
            pending_d = p_TxReq_i;
          end else begin
            if (AcqSig_i) begin
              cnt_d = cnt_inc;
            end
            // A request in the timeout cycle wins over the miss report.
            if (p_TxReq_i) begin
              tx_start_d = 1'b1;
              state_d    = ST_IDLE;
            end else if (timed_out) begin
              tx_missed_d = 1'b1;
              state_d     = ST_IDLE;
            end
          end
        end

        default: begin
          state_d   = ST_IDLE;
          pending_d = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      p_TxStart_o  <= 1'b0;
      p_TxMissed_o <= 1'b0;
      Busy_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      p_TxStart_o  <= tx_start_d;
      p_TxMissed_o <= tx_missed_d;
      Busy_o       <= (state_d != ST_IDLE);
    end
  end

  assign DelayCnt_o = cnt_q;
  assign State_o    = state_q;

endmodule

// File: tb/tb_ans_delay_generator.sv
// tb_ans_delay_generator
// Self-checking bench for ans_delay_generator: a table of frame-turnaround
// vectors plus hand-written sequences for reset, retrigger, abort, DelaySet=0,
// idle requests and counter saturation. Every TX start / miss pulse the DUT
// emits is matched against a queue of expected events.
module tb_ans_delay_generator;

  localparam int unsigned CW = 16;
  localparam int K_START = 1;
  localparam int K_MISS  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] DelaySet_i = '0;
  logic [CW-1:0] MaxWait_i = '0;
  logic          p_RxFrameEnd_i = 1'b0;
  logic          p_TxReq_i = 1'b0;
  logic          p_Abort_i = 1'b0;
  logic          AcqSig_i = 1'b0;
  logic          p_TxStart_o;
  logic          p_TxMissed_o;
  logic          Busy_o;
  logic [CW-1:0] DelayCnt_o;
  logic [1:0]    State_o;

  ans_delay_generator #(.CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .DelaySet_i     (DelaySet_i),
    .MaxWait_i      (MaxWait_i),
    .p_RxFrameEnd_i (p_RxFrameEnd_i),
    .p_TxReq_i      (p_TxReq_i),
    .p_Abort_i      (p_Abort_i),
    .AcqSig_i       (AcqSig_i),
    .p_TxStart_o    (p_TxStart_o),
    .p_TxMissed_o   (p_TxMissed_o),
    .Busy_o         (Busy_o),
    .DelayCnt_o     (DelayCnt_o),
    .State_o        (State_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cnt;
  } exp_t;

  typedef struct {
    int delaySet;
    int maxWait;
    int reqTick;   // -1: no request; 0: right after frame end; k: right after tick k
    int expKind;   // expected event: K_START or K_MISS
    int expCnt;    // expected DelayCnt_o at the event and afterwards
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[10];
  int   nAssert = 0;
  int   nFail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: the edge captures current inputs, then step just past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    repeat (3) cyc();
    AcqSig_i = 1'b1;
    cyc();
    AcqSig_i = 1'b0;
  endtask

  task automatic pulse_req();
    p_TxReq_i = 1'b1;
    cyc();
    p_TxReq_i = 1'b0;
  endtask

  task automatic pulse_frame_end();
    p_RxFrameEnd_i = 1'b1;
    cyc();
    p_RxFrameEnd_i = 1'b0;
  endtask

  // Scoreboard: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && (p_TxStart_o || p_TxMissed_o)) begin
      check("pulse_exclusive", 32'(p_TxStart_o & p_TxMissed_o), 32'd0);
      if (sbq.size() == 0) begin
        nAssert++;
        nFail++;
        $display("FAIL unexpected_pulse: start=%0b missed=%0b cnt=%0d, expected no pulse (t=%0t)",
                 p_TxStart_o, p_TxMissed_o, DelayCnt_o, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("event_kind", p_TxStart_o ? 32'(K_START) : 32'(K_MISS), 32'(e.kind));
        check("event_cnt", 32'(DelayCnt_o), 32'(e.cnt));
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    DelaySet_i = CW'(v.delaySet);
    MaxWait_i  = CW'(v.maxWait);
    sbq.push_back('{v.expKind, v.expCnt});
    pulse_frame_end();
    if (v.reqTick == 0) pulse_req();
    k = 0;
    while (State_o != 2'b00 && k < 40) begin
      k++;
      tick();
      if (k == v.reqTick) pulse_req();
    end
    repeat (3) cyc();
    check($sformatf("vec%0d_state", idx), 32'(State_o), 32'd0);
    check($sformatf("vec%0d_busy", idx), 32'(Busy_o), 32'd0);
    check($sformatf("vec%0d_cnt", idx), 32'(DelayCnt_o), 32'(v.expCnt));
    check($sformatf("vec%0d_event_seen", idx), 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    vecs[0] = '{10, 0,  3, K_START, 10};
    vecs[1] = '{10, 0, 10, K_START, 10};
    vecs[2] = '{10, 0, 14, K_START, 14};
    vecs[3] = '{ 5, 4, -1, K_MISS,   9};
    vecs[4] = '{ 5, 4,  9, K_START,  9};  // request coincides with the wait expiry
    vecs[5] = '{ 5, 4,  7, K_START,  7};
    vecs[6] = '{ 0, 0,  0, K_START,  0};
    vecs[7] = '{ 3, 2, -1, K_MISS,   5};
    vecs[8] = '{ 1, 1, -1, K_MISS,   2};
    vecs[9] = '{ 6, 3,  2, K_START,  6};

    // Reset state
    repeat (2) cyc();
    check("rst_start", 32'(p_TxStart_o), 32'd0);
    check("rst_missed", 32'(p_TxMissed_o), 32'd0);
    check("rst_busy", 32'(Busy_o), 32'd0);
    check("rst_cnt", 32'(DelayCnt_o), 32'd0);
    check("rst_state", 32'(State_o), 32'd0);
    @(negedge clk) rst = 1'b1;
    cyc();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Request in IDLE: start on the very next cycle
    sbq.push_back('{K_START, int'(DelayCnt_o)});
    p_TxReq_i = 1'b1;
    cyc();
    p_TxReq_i = 1'b0;
    @(negedge clk);
    check("idle_req_start_next", 32'(p_TxStart_o), 32'd1);
    check("idle_req_state", 32'(State_o), 32'd0);
    repeat (2) cyc();

    // DelaySet=0 with frame end and request together: start two cycles later
    DelaySet_i = '0;
    MaxWait_i  = '0;
    sbq.push_back('{K_START, 0});
    p_RxFrameEnd_i = 1'b1;
    p_TxReq_i      = 1'b1;
    cyc();
    p_RxFrameEnd_i = 1'b0;
    p_TxReq_i      = 1'b0;
    @(negedge clk);
    check("d0_start_not_yet", 32'(p_TxStart_o), 32'd0);
    check("d0_state_delay", 32'(State_o), 32'd1);
    cyc();
    @(negedge clk);
    check("d0_start_two_cycles", 32'(p_TxStart_o), 32'd1);
    repeat (2) cyc();

    // Retrigger: second frame end restarts the count, one start 8 ticks later
    DelaySet_i = CW'(8);
    sbq.push_back('{K_START, 8});
    pulse_frame_end();
    tick();
    tick();
    pulse_req();
    repeat (4) tick();
    check("retrig_cnt_before", 32'(DelayCnt_o), 32'd6);
    pulse_frame_end();
    check("retrig_cnt_cleared", 32'(DelayCnt_o), 32'd0);
    repeat (7) tick();
    check("retrig_still_delay", 32'(State_o), 32'd1);
    tick();
    @(negedge clk);
    check("retrig_no_start_at_tick", 32'(p_TxStart_o), 32'd0);
    cyc();
    @(negedge clk);
    check("retrig_start", 32'(p_TxStart_o), 32'd1);
    repeat (10) tick();
    check("retrig_single_pulse", 32'(sbq.size()), 32'd0);
    check("retrig_idle", 32'(State_o), 32'd0);

    // Abort in ARMED together with a request: back to IDLE, no start
    DelaySet_i = CW'(2);
    MaxWait_i  = '0;
    pulse_frame_end();
    tick();
    tick();
    repeat (2) cyc();
    check("abort_armed", 32'(State_o), 32'd2);
    p_Abort_i = 1'b1;
    p_TxReq_i = 1'b1;
    cyc();
    p_Abort_i = 1'b0;
    p_TxReq_i = 1'b0;
    check("abort_state", 32'(State_o), 32'd0);
    repeat (4) cyc();
    check("abort_busy", 32'(Busy_o), 32'd0);
    check("abort_cnt_held", 32'(DelayCnt_o), 32'd2);

    // Reset mid-DELAY with a pending request: everything cleared, no start afterwards
    DelaySet_i = CW'(10);
    pulse_frame_end();
    pulse_req();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("midrst_start", 32'(p_TxStart_o), 32'd0);
    check("midrst_missed", 32'(p_TxMissed_o), 32'd0);
    check("midrst_busy", 32'(Busy_o), 32'd0);
    check("midrst_cnt", 32'(DelayCnt_o), 32'd0);
    check("midrst_state", 32'(State_o), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (12) tick();
    check("midrst_after_state", 32'(State_o), 32'd0);
    check("midrst_after_cnt", 32'(DelayCnt_o), 32'd0);

    // MaxWait=0 in ARMED: waits forever, counter saturates at all-ones
    DelaySet_i = CW'(5);
    MaxWait_i  = '0;
    pulse_frame_end();
    AcqSig_i = 1'b1;
    repeat (65540) cyc();
    AcqSig_i = 1'b0;
    cyc();
    check("sat_cnt", 32'(DelayCnt_o), 32'h0000_FFFF);
    check("sat_state_armed", 32'(State_o), 32'd2);
    check("sat_busy", 32'(Busy_o), 32'd1);
    p_Abort_i = 1'b1;
    cyc();
    p_Abort_i = 1'b0;
    check("sat_abort_state", 32'(State_o), 32'd0);
    check("sat_abort_cnt_held", 32'(DelayCnt_o), 32'h0000_FFFF);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
